// File: rtl/rtc_counter.sv
// Real-time clock core: 1 s prescaler, cascaded sec/min/hour, run-time load, 12/24 h view, scan strobe.
// Optional alarm comparator is compiled in when RTC_ALARM_EN is defined.
module rtc_counter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_vld,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
`ifdef RTC_ALARM_EN
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  output logic       alarm_hit,
`endif
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [4:0] hour_disp,
  output logic       pm,
  output logic       tick_1s,
  output logic       day_wrap,
  output logic       set_err,
  output logic       flag_scan
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_FREQ - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;
  logic          flag_q, flag_d;
  logic          adv_s;
  logic          load_ok_s;

  // Time/prescaler next state; a load request always wins over a coincident advance.
  always_comb begin
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pre_d     = pre_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    adv_s     = run && (pre_q == PRE_MAX);
    load_ok_s = (set_hour < 5'd24) && (set_min < 6'd60) && (set_sec < 6'd60);
    if (set_vld) begin
      if (load_ok_s) begin
        hour_d = set_hour;
        min_d  = set_min;
        sec_d  = set_sec;
        pre_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (adv_s) begin
      pre_d  = '0;
      tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d = 5'd0;
            wrap_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (run) begin
      pre_d = pre_q + PW'(1);
    end else begin
      pre_d = pre_q;
    end
  end

  // Free-running scan divider, independent of run and load.
  always_comb begin
    flag_d = (scan_q == SCAN_MAX);
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
    end else begin
      scan_d = scan_q + SW'(1);
    end
  end

  // State and registered pulse outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hour_q <= 5'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
      pre_q  <= '0;
      scan_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      pre_q  <= pre_d;
      scan_q <= scan_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      flag_q <= flag_d;
    end
  end

`ifdef RTC_ALARM_EN
  logic alarm_q, alarm_d;

  // Fires only when an advance lands on the alarm minute; loads are excluded via tick_d.
  always_comb begin
    alarm_d = tick_d && alarm_en && (hour_d == alarm_hour) &&
              (min_d == alarm_min) && (sec_d == 6'd0);
  end

  // Alarm pulse register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm_hit = alarm_q;
`endif

  // 12-hour view: midnight/noon both read 12, pm from 12:00 onward.
  always_comb begin
    hour_disp = hour_q;
    pm        = 1'b0;
    if (mode_12h) begin
      pm = (hour_q >= 5'd12);
      if (hour_q == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour_q > 5'd12) begin
        hour_disp = hour_q - 5'd12;
      end else begin
        hour_disp = hour_q;
      end
    end else begin
      hour_disp = hour_q;
    end
  end

  assign hour      = hour_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign tick_1s   = tick_q;
  assign day_wrap  = wrap_q;
  assign set_err   = err_q;
  assign flag_scan = flag_q;

endmodule

// File: tb/tb_rtc_counter.sv
// Bench for rtc_counter (CLK_FREQ=10, SCAN_DIV=4): seconds-of-day reference model plus directed literal checks.
module tb_rtc_counter;
  localparam int CF = 10;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       run = 1'b0;
  logic       mode_12h = 1'b0;
  logic       set_vld = 1'b0;
  logic [4:0] set_hour = 5'd0;
  logic [5:0] set_min = 6'd0;
  logic [5:0] set_sec = 6'd0;
  logic [4:0] hour, hour_disp;
  logic [5:0] min, sec;
  logic       pm, tick_1s, day_wrap, set_err, flag_scan;
`ifdef RTC_ALARM_EN
  logic       alarm_en = 1'b0;
  logic [4:0] alarm_hour = 5'd0;
  logic [5:0] alarm_min = 6'd0;
  logic       alarm_hit;
`endif

  rtc_counter #(.CLK_FREQ(CF), .SCAN_DIV(SD)) dut (
    .clk(clk), .rstn(rstn), .run(run), .mode_12h(mode_12h),
    .set_vld(set_vld), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
`ifdef RTC_ALARM_EN
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_hit(alarm_hit),
`endif
    .hour(hour), .min(min), .sec(sec), .hour_disp(hour_disp), .pm(pm),
    .tick_1s(tick_1s), .day_wrap(day_wrap), .set_err(set_err), .flag_scan(flag_scan)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time of day as seconds since midnight, edges counted since reset.
  int m_tod = 0;
  int m_pre = 0;
  int m_edges = 0;
  bit m_tick = 1'b0, m_wrap = 1'b0, m_err = 1'b0, m_flag = 1'b0, m_alarm = 1'b0;

`ifdef RTC_ALARM_EN
  function automatic bit alarm_at(input int t);
    return (t / 3600 == int'(alarm_hour)) && ((t / 60) % 60 == int'(alarm_min)) && (t % 60 == 0);
  endfunction
`endif

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_tod <= 0; m_pre <= 0; m_edges <= 0;
      m_tick <= 1'b0; m_wrap <= 1'b0; m_err <= 1'b0; m_flag <= 1'b0; m_alarm <= 1'b0;
    end else begin
      m_edges <= m_edges + 1;
      m_flag  <= ((m_edges + 1) % SD) == 0;
      m_tick <= 1'b0; m_wrap <= 1'b0; m_err <= 1'b0; m_alarm <= 1'b0;
      if (set_vld) begin
        if (set_hour < 24 && set_min < 60 && set_sec < 60) begin
          m_tod <= int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
          m_pre <= 0;
        end else begin
          m_err <= 1'b1;
        end
      end else if (run) begin
        if (m_pre == CF - 1) begin
          m_pre  <= 0;
          m_tod  <= (m_tod + 1) % 86400;
          m_tick <= 1'b1;
          m_wrap <= (m_tod == 86399);
`ifdef RTC_ALARM_EN
          m_alarm <= alarm_en && alarm_at((m_tod + 1) % 86400);
`endif
        end else begin
          m_pre <= m_pre + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int h;
    h = m_tod / 3600;
    chk("hour", hour, h);
    chk("min", min, (m_tod / 60) % 60);
    chk("sec", sec, m_tod % 60);
    chk("hour_disp", hour_disp, mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h);
    chk("pm", pm, mode_12h && h >= 12);
    chk("tick_1s", tick_1s, m_tick);
    chk("day_wrap", day_wrap, m_wrap);
    chk("set_err", set_err, m_err);
    chk("flag_scan", flag_scan, m_flag);
`ifdef RTC_ALARM_EN
    chk("alarm_hit", alarm_hit, m_alarm);
`endif
  end

  task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    @(posedge clk); #1;
    set_vld = 1'b1; set_hour = h; set_min = m; set_sec = s;
    @(posedge clk); #1;
    set_vld = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (tick_1s === 1'b1) return;
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  int hs[4] = '{0, 11, 12, 13};
  int ed[4] = '{12, 11, 12, 1};
  int ep[4] = '{0, 0, 1, 1};

  initial begin
    int n;
    mode_12h = 1'b1; run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hour", hour, 0); chk("rst_sec", sec, 0); chk("rst_tick", tick_1s, 0);
    chk("rst_disp12", hour_disp, 12); chk("rst_pm", pm, 0);
    mode_12h = 1'b0;
    rstn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      chk("tick_cycle", tick_1s, (k % 10) == 0);
      if (k <= 12) chk("flag_cycle", flag_scan, (k % 4) == 0);
    end
    chk("sec_after3", sec, 3); chk("min_after3", min, 0);

    load(5'd23, 6'd59, 6'd58);
    chk("load_h", hour, 23); chk("load_s", sec, 58);
    wait_tick(n);
    chk("load_to_tick", n, 10); chk("t1_sec", sec, 59); chk("t1_wrap", day_wrap, 0);
    wait_tick(n);
    chk("wrap_h", hour, 0); chk("wrap_m", min, 0); chk("wrap_s", sec, 0); chk("wrap_pulse", day_wrap, 1);

    load(5'd24, 6'd0, 6'd0);
    chk("err24", set_err, 1); chk("err24_h", hour, 0); chk("err24_s", sec, 0);
    @(posedge clk); #1; chk("err24_once", set_err, 0);
    load(5'd10, 6'd60, 6'd0);
    chk("err60", set_err, 1); chk("err60_h", hour, 0); chk("err60_m", min, 0);
    @(posedge clk); #1; chk("err60_once", set_err, 0);

    wait_tick(n);
    repeat (9) @(posedge clk);
    #1; set_vld = 1'b1; set_hour = 5'd5; set_min = 6'd6; set_sec = 6'd7;
    @(posedge clk); #1; set_vld = 1'b0;
    chk("coinc_h", hour, 5); chk("coinc_m", min, 6); chk("coinc_s", sec, 7); chk("coinc_tick", tick_1s, 0);
    wait_tick(n);
    chk("coinc_gap", n, 10); chk("coinc_next", sec, 8);

    run = 1'b0; mode_12h = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load(5'(hs[i]), 6'd0, 6'd0);
      chk("disp12", hour_disp, ed[i]); chk("pm12", pm, ep[i]);
    end

`ifdef RTC_ALARM_EN
    run = 1'b1; alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
    load(5'd7, 6'd29, 6'd59);
    wait_tick(n);
    chk("alarm_on", alarm_hit, 1); chk("alarm_min", min, 30);
    alarm_en = 1'b0;
    load(5'd7, 6'd29, 6'd59);
    wait_tick(n);
    chk("alarm_off", alarm_hit, 0);
    alarm_en = 1'b1;
    load(5'd7, 6'd30, 6'd0);
    chk("alarm_load", alarm_hit, 0);
`endif

    run = 1'b1;
    load(5'd13, 6'd45, 6'd12);
    repeat (5) @(posedge clk);
    #2; rstn = 1'b0; #1;
    chk("mid_rst_h", hour, 0); chk("mid_rst_m", min, 0); chk("mid_rst_s", sec, 0);
    chk("mid_rst_tick", tick_1s, 0); chk("mid_rst_flag", flag_scan, 0); chk("mid_rst_err", set_err, 0);
    @(negedge clk); rstn = 1'b1;

    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      run = ($urandom_range(0, 9) != 0);
      mode_12h = $urandom_range(0, 1) == 1;
      set_vld = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1) begin
        set_hour = 5'($urandom_range(22, 23)); set_min = 6'($urandom_range(58, 59));
        set_sec = 6'($urandom_range(50, 59));
      end else begin
        set_hour = 5'($urandom_range(0, 31)); set_min = 6'($urandom_range(0, 63));
        set_sec = 6'($urandom_range(0, 63));
      end
`ifdef RTC_ALARM_EN
      if ($urandom_range(0, 99) == 0) begin
        alarm_en = $urandom_range(0, 3) != 0;
        alarm_hour = 5'($urandom_range(22, 23)); alarm_min = 6'($urandom_range(58, 59));
      end
`endif
    end
    set_vld = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rtc_counter.md
# rtc_counter

Parametrised real-time clock core for the seven-segment clock designs. It derives a 1 s tick from the system clock and keeps cascaded seconds, minutes and hours registers, so no division is needed on the output. It also supports loading the time at run time, a run/pause control, a 12/24-hour display view and an independent display-scan strobe. The seg-drive logic consumes its time fields and scan strobe.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: clock cycles per second; prescaler width is $clog2(CLK_FREQ).
- SCAN_DIV, 1000: period of flag_scan in clock cycles (≥2).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- run  in  1  1 = time advances; 0 = prescaler and time frozen
- mode_12h  in  1  selects 12-hour view on hour_disp/pm
- set_vld  in  1  one-cycle load request
- set_hour  in  5  load value, 0–23
- set_min  in  6  load value, 0–59
- set_sec  in  6  load value, 0–59
- hour  out  5  24-hour value, registered
- min  out  6  registered
- sec  out  6  registered
- hour_disp  out  5  display hour, combinational from hour and mode_12h
- pm  out  1  combinational
- tick_1s  out  1  one-cycle pulse per advanced second, registered
- day_wrap  out  1  one-cycle pulse on 23:59:59 → 00:00:00, registered
- set_err  out  1  one-cycle pulse on a rejected load, registered
- flag_scan  out  1  one-cycle pulse every SCAN_DIV cycles, registered

## Operation
- Reset values: all registers and registered outputs are 0. With mode_12h=1 during reset, hour_disp=12 and pm=0.
- Prescaler cnt_pre counts 0..CLK_FREQ-1 while run=1 and holds while run=0.
- Advance event: run=1 and cnt_pre==CLK_FREQ-1.
  - cnt_pre returns to 0 and tick_1s is 1 next cycle.
  - sec increments. At 59 it wraps to 0 and min increments.
  - min at 59 wraps to 0 and hour increments. hour at 23 wraps to 0.
  - On a full 23:59:59 wrap, day_wrap pulses in the same cycle as tick_1s.
- Load: a load is valid when set_hour<24, set_min<60 and set_sec<60.
  - A valid load replaces hour/min/sec at the next edge and clears cnt_pre to 0. The next tick comes a full CLK_FREQ cycles later.
  - An invalid load leaves time and cnt_pre unchanged and pulses set_err for 1 cycle.
  - set_vld has priority over a coincident advance event. That advance is suppressed, with no tick_1s or day_wrap.
  - Loading works regardless of run.
- Display view:
  - mode_12h=0: hour_disp=hour, pm=0.
  - mode_12h=1: hour 0 → 12; hour 1–12 → unchanged; hour 13–23 → hour-12; pm = (hour ≥ 12).
- Scan strobe: cnt_scan counts 0..SCAN_DIV-1 continuously, independent of run and set_vld. flag_scan is 1 in the cycle after cnt_scan==SCAN_DIV-1.

## Timing
- Time fields update on the same edge that raises tick_1s, with no skew between fields.
- First tick_1s goes high at the end of clock cycle CLK_FREQ after reset release, given run=1 throughout.
- First flag_scan goes high at the end of cycle SCAN_DIV after reset release; it then repeats every SCAN_DIV cycles.
- Load latency is 1 cycle, from set_vld sampled high to new hour/min/sec visible, or to set_err high.
- Deasserting run mid-second keeps the partial prescaler count. Reasserting run resumes from it.
- Asserting rstn low at any time clears all state immediately, including any pulse in flight.

## Configuration
- Macro: RTC_ALARM_EN.
- Defined:
  - Adds inputs alarm_en (1), alarm_hour (5) and alarm_min (6), plus output alarm_hit (1, registered, reset 0).
  - alarm_hit pulses 1 cycle, coincident with tick_1s, when an advance or wrap makes hour==alarm_hour, min==alarm_min and sec==0 while alarm_en=1.
  - A load that lands on the alarm time does not fire alarm_hit.
- Undefined: these ports and that logic are absent; all other behaviour is identical.

## Test plan
- CLK_FREQ=10, SCAN_DIV=4, run=1 from reset:
  - tick_1s is high at the end of cycles 10, 20 and 30.
  - After the 3rd tick, sec=3.
  - flag_scan is high at the end of cycles 4, 8 and 12.
- Load 23:59:58, then run 2 s:
  - 1st tick gives 23:59:59.
  - 2nd tick gives 00:00:00 with day_wrap=1 in the same cycle as tick_1s.
- Load 24:00:00 and then 10:60:00:
  - Each raises set_err for exactly 1 cycle.
  - Time stays unchanged.
- set_vld coincident with an advance event, loading 05:06:07:
  - Next state is 05:06:07.
  - tick_1s stays 0.
  - Next tick comes 10 cycles later, giving 05:06:08.
- mode_12h=1 with hour 0, 11, 12 and 13:
  - hour_disp reads 12, 11, 12, 1.
  - pm reads 0, 0, 1, 1.
- With RTC_ALARM_EN:
  - alarm_en=1, alarm 07:30; load 07:29:59; run 1 s: alarm_hit is 1 in the tick cycle.
  - alarm_en=0, same sequence: alarm_hit is 0.
  - Reset mid-count: all outputs are 0 immediately.
